// File: rtl/ysyx_23060332_dmem_resp_pkg.sv
// Shared types and defaults for the data-memory responder.
package ysyx_23060332_dmem_resp_pkg;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'h8000_0000;
  localparam int          DEPTH_WORDS_DEF = 4096;
  localparam int          CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  // Byte lanes touched by a store; bits [7:4] set means it crosses the word.
  function automatic logic [7:0] lane_shift(input logic [3:0] mask, input logic [1:0] b);
    lane_shift = {4'b0000, mask} << b;
  endfunction

endpackage

// File: rtl/ysyx_23060332_dmem_resp_if.sv
// Load/store request and response bundle between the EXU/LSU and the responder.
interface ysyx_23060332_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] mem_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask, rsp_ready,
    input  req_ready, rsp_valid, mem_rdata, rsp_err
  );

  modport slave (
    input  req_valid, mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask, rsp_ready,
    output req_ready, rsp_valid, mem_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_23060332_sram_bank.sv
// Word-organised SRAM: byte-enable synchronous write, synchronous read, no reset.
module ysyx_23060332_sram_bank #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/ysyx_23060332_dmem_resp.sv
// Data-memory responder: accepts one load/store, commits it after LATENCY cycles.
// IDLE = accepting | WAIT = latency countdown | RESP = response held until rsp_ready
module ysyx_23060332_dmem_resp
  import ysyx_23060332_dmem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int          LATENCY     = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_23060332_dmem_resp_if.slave bus
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             cap_q, cap_d, req_in, cur;
  logic             commit;
  logic             err_q, load_q;
  logic [1:0]       b_q;
  logic [31:0]      off;
  logic [1:0]       b;
  logic [7:0]       lanes;
  logic             err;
  logic [AW-1:0]    idx;
  logic [31:0]      rd_word;
  logic             unused_ok;

  always_comb begin
    req_in       = '0;
    req_in.ren   = bus.mem_ren;
    req_in.wen   = bus.mem_wen;
    req_in.addr  = bus.mem_ren ? bus.mem_raddr : bus.mem_waddr;
    req_in.wdata = bus.mem_wdata;
    req_in.wmask = bus.mem_wmask[3:0];
  end

  // With LATENCY==1 the commit edge is the accept edge, so decode the live request.
  assign cur   = (state_q == ST_IDLE) ? req_in : cap_q;
  assign off   = cur.addr - BASE_ADDR;
  assign b     = cur.addr[1:0];
  assign idx   = off[AW+1:2];
  assign lanes = lane_shift(cur.wmask, b);
  assign err   = (cur.ren | cur.wen) &
                 ((|off[31:AW+2]) | (cur.ren & cur.wen) | (cur.wen & (|lanes[7:4])));

  assign unused_ok = ^{bus.mem_wmask[7:4], off[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cap_d = req_in;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      b_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      if (commit) begin
        err_q  <= err;
        load_q <= cur.ren;
        b_q    <= b;
      end
    end
  end

  ysyx_23060332_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk     (clk),
    .we_i    (commit & cur.wen & ~err),
    .be_i    (lanes[3:0]),
    .addr_i  (idx),
    .wdata_i (cur.wdata << {b, 3'b000}),
    .re_i    (commit & cur.ren & ~err),
    .rdata_o (rd_word)
  );

  // The SRAM read register is only reloaded at commit, so data holds through RESP.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = (state_q == ST_RESP) & err_q;
  assign bus.mem_rdata = ((state_q == ST_RESP) && load_q && !err_q) ? (rd_word >> {b_q, 3'b000}) : '0;

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// Directed bench for the data-memory responder with LATENCY=3.
module tb_ysyx_23060332_dmem_resp;

  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] JUNK = 32'h8000_0FF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_23060332_dmem_resp_if bus ();

  ysyx_23060332_dmem_resp #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (4096),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] mask);
    bus.mem_ren   = ren;
    bus.mem_wen   = wen;
    bus.mem_raddr = ren ? addr : JUNK;
    bus.mem_waddr = ren ? JUNK : addr;
    bus.mem_wdata = wdata;
    bus.mem_wmask = mask;
  endtask

  task automatic xact(input string tag, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] mask,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    @(negedge clk);
    drive(ren, wen, addr, wdata, mask);
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    chk({tag, "_ready"}, bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
    chk({tag, "_err"}, bus.rsp_err, exp_err);
    @(posedge clk);
  endtask

  initial begin
    int lat;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b0, BASE, 32'h0, 8'h00);

    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_err", bus.rsp_err, 0);
    rst_n = 1'b1;

    xact("sw_10", 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0);
    xact("lw_10", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0);

    // Reset during WAIT must drop the pending store.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h8000_0010, 32'h1111_1111, 8'h0F);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("wait_req_ready", bus.req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    xact("lw_after_rst", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0);

    xact("sb_13", 1'b0, 1'b1, 32'h8000_0013, 32'h0000_00AA, 8'h01, 32'h0, 1'b0);
    xact("lw_10_sb", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hAAAD_BEEF, 1'b0);
    xact("lw_13", 1'b1, 1'b0, 32'h8000_0013, 32'h0, 8'h00, 32'h0000_00AA, 1'b0);
    xact("lw_12", 1'b1, 1'b0, 32'h8000_0012, 32'h0, 8'h00, 32'h0000_AAAD, 1'b0);

    xact("sh_13_mis", 1'b0, 1'b1, 32'h8000_0013, 32'h0000_1234, 8'h03, 32'h0, 1'b1);
    xact("sw_12_mis", 1'b0, 1'b1, 32'h8000_0012, 32'h5555_5555, 8'h0F, 32'h0, 1'b1);
    xact("lw_10_nowr", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hAAAD_BEEF, 1'b0);

    xact("lw_below", 1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 32'h0, 1'b1);
    xact("lw_above", 1'b1, 1'b0, 32'h8000_4000, 32'h0, 8'h00, 32'h0, 1'b1);
    xact("ren_wen", 1'b1, 1'b1, 32'h8000_0010, 32'h0, 8'h0F, 32'h0, 1'b1);
    xact("lw_10_rw", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hAAAD_BEEF, 1'b0);
    xact("noop", 1'b0, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'h0, 1'b0);
    xact("sw_last", 1'b0, 1'b1, 32'h8000_3FFC, 32'h0123_4567, 8'h0F, 32'h0, 1'b0);
    xact("lw_last", 1'b1, 1'b0, 32'h8000_3FFC, 32'h0, 8'h00, 32'h0123_4567, 1'b0);

    // Backpressure with a second request already waiting.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h00);
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 32'h8000_0013, 32'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_rdata", bus.mem_rdata, 32'hAAAD_BEEF);
      chk("bp_err", bus.rsp_err, 0);
      chk("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    chk("bp_last_rdata", bus.mem_rdata, 32'hAAAD_BEEF);
    @(negedge clk);
    chk("drain_req_ready", bus.req_ready, 1);
    chk("drain_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    chk("resume_lat", lat, LAT);
    chk("resume_rdata", bus.mem_rdata, 32'h0000_00AA);
    @(posedge clk);
    @(negedge clk);
    chk("final_idle", bus.req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
